// File: rtl/pipe_stage_skid_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid_reg
//
// Generic inter-stage pipeline register with a valid/ready handshake and a
// one-entry skid register behind the main register, for two entries in total.
// The payload travels in a data vector and the control bits in a control
// vector. The control vector is forced to zero whenever no valid entry is
// presented. A squashed instruction therefore never asserts RegWrite,
// MemWrite, etc. downstream.
//
// in_ready depends only on registered state. There is no combinational path
// from out_ready to in_ready, so back-pressure does not ripple through
// chained stages within a single cycle.
//
// Optional feature: define PIPE_STAGE_PERF_EN to add the stall_cycles and
// bubble_cycles performance counters. Both saturate and are cleared only by
// reset.
//
// Ports:
//   clk           in   rising-edge clock
//   reset         in   asynchronous, active-high; empties the stage
//   flush         in   synchronous squash of all held entries
//   in_valid      in   producer presents an entry
//   in_ready      out  stage can accept (low only when both entries are held)
//   in_data       in   producer payload            [DATA_W]
//   in_ctrl       in   producer control            [CTRL_W]
//   out_valid     out  out_data/out_ctrl carry a valid entry
//   out_ready     in   consumer accepts
//   out_data      out  payload to next stage       [DATA_W]
//   out_ctrl      out  control to next stage, 0 whenever out_valid=0 [CTRL_W]
//   occupancy     out  number of entries held: 0, 1 or 2
//   stall_cycles  out  (PIPE_STAGE_PERF_EN) cycles with in_valid & !in_ready
//   bubble_cycles out  (PIPE_STAGE_PERF_EN) cycles with out_ready & !out_valid
// ---------------------------------------------------------------------------
module pipe_stage_skid_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       bubble_cycles
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic              in_xfer;
    logic              out_xfer;
    logic              main_ld;
    logic              main_from_skid;
    logic              skid_ld;

    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;

    // The state encoding equals the entry count. FULL is the state in which
    // the skid register holds an entry.
    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign occupancy = state;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    assign out_data = main_data;
    // Bubbles never leak stale control bits downstream.
    assign out_ctrl = out_valid ? main_ctrl : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        main_ld        = 1'b0;
        main_from_skid = 1'b0;
        skid_ld        = 1'b0;
        if (flush) begin
            // Flush wins over everything. An input accepted in this cycle is
            // dropped. An output taken in this cycle has already been
            // consumed downstream, so dropping the held entries loses nothing
            // that still needs delivering.
            state_nxt = EMPTY;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (in_xfer) begin
                        main_ld   = 1'b1;
                        state_nxt = ONE;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_ld = 1'b1;
                    end else if (in_xfer) begin
                        skid_ld   = 1'b1;
                        state_nxt = FULL;
                    end else if (out_xfer) begin
                        state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    if (out_xfer) begin
                        main_ld        = 1'b1;
                        main_from_skid = 1'b1;
                        state_nxt      = ONE;
                    end
                end
                default: begin
                    state_nxt = EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_data <= '0;
            main_ctrl <= '0;
            skid_data <= '0;
            skid_ctrl <= '0;
        end else begin
            if (main_ld) begin
                main_data <= main_from_skid ? skid_data : in_data;
                main_ctrl <= main_from_skid ? skid_ctrl : in_ctrl;
            end
            if (skid_ld) begin
                skid_data <= in_data;
                skid_ctrl <= in_ctrl;
            end
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Flush does not clear these counters, because they measure the whole run.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles  <= '0;
            bubble_cycles <= '0;
        end else begin
            if (in_valid && !in_ready) begin
                stall_cycles <= sat_inc(stall_cycles);
            end
            if (out_ready && !out_valid) begin
                bubble_cycles <= sat_inc(bubble_cycles);
            end
        end
    end
`endif

endmodule
